prach_uplane_sched: RTL and testbench

- Round-robin scheduler on the clk_eth_xran side that shares the single O-RAN U-Plane Avalon-ST source among the PRACH channel buffers (8 antennas x 3 CC).
- Grants one channel buffer at a time and reads its completed section through a 1-cycle-latency read port.
- Forwards the section as one packet with SOP/EOP and generates the U-Plane header fields tx_u_size, tx_u_pc_id and tx_u_seq_id per packet.

---
 rtl/prach_pkg.sv | 29 ++
 rtl/prach_sched_fifo.sv | 46 ++++
 rtl/prach_uplane_sched.sv | 174 +++++++++++++++++
 tb/tb_prach_uplane_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prach_pkg.sv
// Shared types and constants for the PRACH U-Plane scheduler: channel geometry,
// scheduler states and the tagged entry carried through the output skid FIFO.
package prach_pkg;

  localparam int NUM_CH = 24;
  localparam int CH_W   = 5;
  localparam int BEAT_W = 8;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ZERO = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [15:0] size;
    logic [15:0] pc_id;
    logic [15:0] seq_id;
  } uplane_hdr_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    uplane_hdr_t       hdr;
  } skid_entry_t;

endpackage

// File: rtl/prach_sched_fifo.sv
// Shift-register FIFO of tagged U-Plane beats; entry 0 is the head register,
// so the head only changes on a pop or when a push lands in an empty FIFO.
module prach_sched_fifo
  import prach_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  skid_entry_t      push_entry,
  input  logic             pop,
  output skid_entry_t      head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  skid_entry_t      mem [DEPTH];
  logic [CNT_W-1:0] wr_idx;

  // A simultaneous pop shifts everything down, so the push lands one slot lower.
  assign wr_idx     = pop ? count - CNT_W'(1) : count;
  assign head       = mem[0];
  assign head_valid = (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem[i] <= mem[i+1];
        end
      end
      if (push && (int'(wr_idx) < DEPTH)) begin
        mem[wr_idx] <= push_entry;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/prach_uplane_sched.sv
// Round-robin scheduler sharing one U-Plane Avalon-ST source among PRACH channel
// buffers; reads a granted section beat by beat and emits it as one packet.
module prach_uplane_sched
  import prach_pkg::*;
#(
  parameter int SKID_DEPTH = 4
) (
  input  logic                     clk_eth_xran,
  input  logic                     rst_eth_xran,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*BEAT_W-1:0] req_beats,
  output logic [NUM_CH-1:0]        req_done,
  output logic                     rd_en,
  output logic [CH_W-1:0]          rd_ch,
  input  logic [DATA_W-1:0]        rd_data,
  output logic [DATA_W-1:0]        avst_source_u_data,
  output logic                     avst_source_u_valid,
  output logic                     avst_source_u_startofpacket,
  output logic                     avst_source_u_endofpacket,
  input  logic                     avst_source_u_ready,
  output logic [15:0]              tx_u_size,
  output logic [15:0]              tx_u_pc_id,
  output logic [15:0]              tx_u_seq_id,
  output logic                     err_zero_len
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  sched_state_t      state, state_d;
  logic [CH_W-1:0]   grant_ch, rr_ptr, pick_ch;
  logic              pick_any;
  logic [BEAT_W-1:0] remaining, pick_beats;
  logic              first_rd;
  uplane_hdr_t       grant_hdr;
  logic [7:0]        seq [NUM_CH];
  logic [NUM_CH-1:0] eligible;

  logic              inflight, inflight_sop, inflight_eop;
  uplane_hdr_t       inflight_hdr;
  skid_entry_t       push_entry, head;
  logic              head_valid, pop, room;
  logic [CNT_W-1:0]  fifo_count;

  assign eligible   = req_valid & ch_enable;
  assign pick_beats = req_beats[int'(pick_ch)*BEAT_W +: BEAT_W];

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    pick_any = 1'b0;
    pick_ch  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!pick_any && eligible[(int'(rr_ptr) + k) % NUM_CH]) begin
        pick_any = 1'b1;
        pick_ch  = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end

  // Reads in flight still need a FIFO slot, so they count against the depth.
  assign room = (int'(fifo_count) + int'(inflight)) < SKID_DEPTH;

  always_comb begin
    state_d  = state;
    rd_en    = 1'b0;
    req_done = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_d = (pick_beats == '0) ? ZERO : XFER;
        end
      end
      XFER: begin
        if (room) begin
          rd_en = 1'b1;
          if (remaining == BEAT_W'(1)) begin
            req_done[grant_ch] = 1'b1;
            state_d            = IDLE;
          end
        end
      end
      ZERO: begin
        req_done[grant_ch] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_eth_xran) begin
    if (rst_eth_xran) begin
      state        <= IDLE;
      grant_ch     <= '0;
      rr_ptr       <= CH_W'(NUM_CH - 1);
      remaining    <= '0;
      first_rd     <= 1'b0;
      grant_hdr    <= '0;
      inflight     <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
      inflight_hdr <= '0;
      err_zero_len <= 1'b0;
    end else begin
      state    <= state_d;
      inflight <= rd_en;
      if (rd_en) begin
        inflight_sop <= first_rd;
        inflight_eop <= (remaining == BEAT_W'(1));
        inflight_hdr <= grant_hdr;
        remaining    <= remaining - BEAT_W'(1);
        first_rd     <= 1'b0;
      end
      if (state == IDLE && pick_any) begin
        grant_ch         <= pick_ch;
        rr_ptr           <= pick_ch;
        remaining        <= pick_beats;
        first_rd         <= 1'b1;
        grant_hdr.size   <= {4'd0, pick_beats, 4'd0};
        grant_hdr.pc_id  <= 16'(pick_ch);
        grant_hdr.seq_id <= {seq[pick_ch], 1'b1, 7'd0};
      end
      if (state == ZERO) begin
        err_zero_len <= 1'b1;
      end
    end
  end

  // A channel's sequence number advances only once its SOP beat is taken by the sink.
  always_ff @(posedge clk_eth_xran) begin
    if (rst_eth_xran) begin
      for (int c = 0; c < NUM_CH; c++) begin
        seq[c] <= '0;
      end
    end else if (pop && head.sop) begin
      seq[head.hdr.pc_id[CH_W-1:0]] <= seq[head.hdr.pc_id[CH_W-1:0]] + 8'd1;
    end
  end

  assign push_entry.data = rd_data;
  assign push_entry.sop  = inflight_sop;
  assign push_entry.eop  = inflight_eop;
  assign push_entry.hdr  = inflight_hdr;

  // Avalon-ST: a beat moves when valid & ready; the head register holds while stalled.
  assign pop = head_valid & avst_source_u_ready;

  prach_sched_fifo #(
    .DEPTH (SKID_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk_eth_xran),
    .rst        (rst_eth_xran),
    .push       (inflight),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign rd_ch                       = grant_ch;
  assign avst_source_u_data          = head.data;
  assign avst_source_u_valid         = head_valid;
  assign avst_source_u_startofpacket = head.sop;
  assign avst_source_u_endofpacket   = head.eop;
  assign tx_u_size                   = head.hdr.size;
  assign tx_u_pc_id                  = head.hdr.pc_id;
  assign tx_u_seq_id                 = head.hdr.seq_id;

  // The granted buffer must keep its request up until the section is fully read.
  a_req_held: assert property (@(posedge clk_eth_xran) disable iff (rst_eth_xran)
    (state == XFER && !req_done[grant_ch]) |-> req_valid[grant_ch]);

endmodule

// File: tb/tb_prach_uplane_sched.sv
// Scoreboard bench for prach_uplane_sched: directed requests push expected beats,
// a negedge monitor models the channel buffers and checks every accepted beat.
module tb_prach_uplane_sched;
  import prach_pkg::*;

  localparam int EXP_W = DATA_W + 2 + 48;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_enable;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*BEAT_W-1:0] req_beats;
  logic [NUM_CH-1:0]        req_done;
  logic                     rd_en;
  logic [CH_W-1:0]          rd_ch;
  logic [DATA_W-1:0]        rd_data;
  logic [DATA_W-1:0]        avst_data;
  logic                     avst_valid, avst_sop, avst_eop, ready;
  logic [15:0]              tx_u_size, tx_u_pc_id, tx_u_seq_id;
  logic                     err_zero_len;

  logic [EXP_W-1:0] exp_q[$];
  int posted   [NUM_CH] = '{default: 0};
  int served   [NUM_CH] = '{default: 0};
  int beat_idx [NUM_CH] = '{default: 0};
  int exp_pkt  [NUM_CH] = '{default: 0};
  int exp_seq  [NUM_CH] = '{default: 0};
  int pend_ch = 0, pend_pkt = 0, pend_beat = 0;
  logic pend_v = 1'b0;
  int rd_issued = 0, acc_cnt = 0, acc_total = 0, max_out = 0;
  logic hold_v = 1'b0;
  logic [EXP_W-1:0] hold_act = '0;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  prach_uplane_sched dut (
    .clk_eth_xran                (clk),
    .rst_eth_xran                (rst),
    .ch_enable                   (ch_enable),
    .req_valid                   (req_valid),
    .req_beats                   (req_beats),
    .req_done                    (req_done),
    .rd_en                       (rd_en),
    .rd_ch                       (rd_ch),
    .rd_data                     (rd_data),
    .avst_source_u_data          (avst_data),
    .avst_source_u_valid         (avst_valid),
    .avst_source_u_startofpacket (avst_sop),
    .avst_source_u_endofpacket   (avst_eop),
    .avst_source_u_ready         (ready),
    .tx_u_size                   (tx_u_size),
    .tx_u_pc_id                  (tx_u_pc_id),
    .tx_u_seq_id                 (tx_u_seq_id),
    .err_zero_len                (err_zero_len)
  );

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      req_valid[c] = (posted[c] != served[c]);
    end
  end

  function automatic logic [DATA_W-1:0] beat_data(input int ch, input int pkt, input int beat);
    return {4{8'(ch), 16'(pkt), 8'(beat)}};
  endfunction

  function automatic logic pending_any();
    logic p = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_enable[c] && posted[c] != served[c]) p = 1'b1;
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beats(input int ch, input int beats);
    req_beats[ch*BEAT_W +: BEAT_W] = BEAT_W'(beats);
  endtask

  task automatic expect_pkt(input int ch, input int beats);
    logic [15:0] size, pcid, seqid;
    size  = 16'(beats * 16);
    pcid  = 16'(ch);
    seqid = {8'(exp_seq[ch]), 1'b1, 7'd0};
    for (int b = 0; b < beats; b++) begin
      exp_q.push_back({beat_data(ch, exp_pkt[ch], b), 1'(b == 0), 1'(b == beats - 1),
                       size, pcid, seqid});
    end
    exp_pkt[ch]++;
    exp_seq[ch]++;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pending_any()) && n < budget) begin
      tick();
      n++;
    end
    check({"drain_", name}, EXP_W'(n < budget), EXP_W'(1));
    tick();
    tick();
  endtask

  // Buffer model, read-return driver side: data only during the cycle after rd_en.
  always @(posedge clk) begin
    #1;
    if (pend_v) rd_data = beat_data(pend_ch, pend_pkt, pend_beat);
    else        rd_data = {4{32'hBAD0_BAD0}};
  end

  // Monitor: sink checks, stall stability, read-room tracking and buffer model state.
  always @(negedge clk) begin
    logic [EXP_W-1:0] act, e;
    int outst;
    act   = {avst_data, avst_sop, avst_eop, tx_u_size, tx_u_pc_id, tx_u_seq_id};
    outst = rd_issued - acc_cnt;
    if (hold_v) begin
      check("hold_valid", EXP_W'(avst_valid), EXP_W'(1));
      check("hold_fields", act, hold_act);
    end
    if (avst_valid && ready) begin
      acc_cnt++;
      acc_total++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        check("beat", act, e);
      end
    end
    hold_v   = avst_valid && !ready;
    hold_act = act;
    pend_v   = rd_en;
    if (rd_en) begin
      check("rd_room", EXP_W'(outst < 4), EXP_W'(1));
      rd_issued++;
      pend_ch   = int'(rd_ch);
      pend_pkt  = served[rd_ch];
      pend_beat = beat_idx[rd_ch];
      beat_idx[rd_ch]++;
    end
    if (rd_issued - acc_cnt > max_out) max_out = rd_issued - acc_cnt;
    for (int c = 0; c < NUM_CH; c++) begin
      if (req_done[c]) begin
        served[c]++;
        beat_idx[c] = 0;
      end
    end
    if (rst) begin
      pend_v    = 1'b0;
      hold_v    = 1'b0;
      rd_issued = 0;
      acc_cnt   = 0;
      for (int c = 0; c < NUM_CH; c++) beat_idx[c] = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    int base, n, r0, d0;
    rst       = 1'b1;
    ready     = 1'b1;
    ch_enable = '1;
    req_beats = '0;
    repeat (3) tick();
    check("reset_ctrl", EXP_W'({avst_valid, avst_sop, avst_eop, rd_en, rd_ch, req_done, err_zero_len}), '0);
    check("reset_hdr", EXP_W'({tx_u_size, tx_u_pc_id, tx_u_seq_id}), '0);
    check("reset_data", EXP_W'(avst_data), '0);
    rst = 1'b0;
    tick();

    // Round robin: three channels, two sections each, requests held across done.
    set_beats(0, 2); set_beats(5, 2); set_beats(23, 2);
    for (int r = 0; r < 2; r++) begin
      expect_pkt(0, 2); expect_pkt(5, 2); expect_pkt(23, 2);
    end
    posted[0] += 2; posted[5] += 2; posted[23] += 2;
    wait_drain("rr", 200);

    // Single channel latency and header fields.
    set_beats(3, 4);
    expect_pkt(3, 4);
    posted[3]++;
    @(negedge clk); check("lat_t0_rd", EXP_W'(rd_en), EXP_W'(0));
    @(negedge clk); check("lat_t1_rd", EXP_W'({rd_en, rd_ch}), EXP_W'({1'b1, 5'd3}));
    @(negedge clk);
    @(negedge clk); check("lat_t3_sop", EXP_W'({avst_valid, avst_sop}), EXP_W'(2'b11));
    @(negedge clk); check("lat_t4_done", EXP_W'(req_done), EXP_W'(24'h8));
    wait_drain("single", 100);

    // Backpressure with ready pattern 1,0,0,1.
    pat = 4'b1001;
    set_beats(1, 10);
    expect_pkt(1, 10);
    posted[1]++;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || posted[1] != served[1]); i++) begin
      ready = pat[i % 4];
      tick();
    end
    ready = 1'b1;
    wait_drain("bp", 50);
    check("bp_fill", EXP_W'(max_out), EXP_W'(4));

    // Zero-length section.
    r0 = rd_issued;
    set_beats(7, 0);
    posted[7]++;
    exp_pkt[7]++;
    repeat (10) tick();
    check("zero_done_once", EXP_W'(served[7]), EXP_W'(1));
    check("zero_no_read", EXP_W'(rd_issued - r0), '0);
    check("zero_err", EXP_W'(err_zero_len), EXP_W'(1));
    set_beats(7, 1);
    expect_pkt(7, 1);
    posted[7]++;
    wait_drain("zero_next", 100);
    check("zero_err_sticky", EXP_W'(err_zero_len), EXP_W'(1));

    // Sequence wrap: 257 one-beat packets on ch2.
    set_beats(2, 1);
    for (int k = 0; k < 257; k++) begin
      expect_pkt(2, 1);
      posted[2]++;
      wait_drain("wrap", 50);
    end

    // Reset in the middle of an 8-beat packet.
    set_beats(0, 8);
    expect_pkt(0, 8);
    base = acc_total;
    posted[0]++;
    n = 0;
    while (acc_total - base < 3 && n < 50) begin
      tick();
      n++;
    end
    check("rst_reach_beat3", EXP_W'(n < 50), EXP_W'(1));
    rst = 1'b1;
    set_beats(4, 1);
    posted[4]++;
    tick();
    check("rst_valid", EXP_W'(avst_valid), '0);
    check("rst_rd", EXP_W'(rd_en), '0);
    check("rst_err", EXP_W'(err_zero_len), '0);
    exp_q.delete();
    exp_pkt[0]--;
    exp_seq = '{default: 0};
    rst = 1'b0;
    expect_pkt(0, 8);
    expect_pkt(4, 1);
    wait_drain("after_rst", 200);

    // Disabled channel is never granted.
    ch_enable[2] = 1'b0;
    r0 = rd_issued;
    d0 = served[2];
    posted[2]++;
    repeat (40) tick();
    check("dis_no_done", EXP_W'(served[2]), EXP_W'(d0));
    check("dis_no_read", EXP_W'(rd_issued - r0), '0);
    check("dis_no_beat", EXP_W'(avst_valid), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
